eth_tx_pkt_buf: RTL and testbench
=================================

// Module: eth_tx_pkt_buf
//
// PURPOSE
//  Single-frame byte buffer feeding the RMII transmit control FSM. Upstream logic writes
//  payload bytes (byte after len/type through end of data) over a valid/ready stream.
//  On the last byte the frame is committed and Eth_Pkt_Rdy is raised. The TX control FSM
//  then pops bytes with Fifo_Rd (one byte per 4 clocks) until Fifo_Empty, and the buffer
//  re-arms once Tx_En drops.
//
// PARAMETERS
//  pDEPTH   1536  payload byte capacity of the buffer (max bytes per frame)
//  pADDR_W  11    pointer/length width; must satisfy 2**pADDR_W >= pDEPTH
//
// PORTS
//  Clk          in   1        system clock (RMII 50 MHz domain)
//  Rst          in   1        synchronous, active-high reset
//  Wr_Data      in   8        payload byte from upstream
//  Wr_Valid     in   1        Wr_Data valid; byte accepted when Wr_Valid & Wr_Ready
//  Wr_Last      in   1        qualifies accepted byte as final byte of frame
//  Wr_Ready     out  1        buffer can accept a byte this cycle
//  Tx_En        in   1        TX FSM transmit-active level
//  Fifo_Rd      in   1        pop request from TX FSM
//  Fifo_Data    out  8        popped byte, registered
//  Fifo_Empty   out  1        no committed unread bytes remain
//  Eth_Pkt_Rdy  out  1        committed frame waiting for transmission
//  Frame_Len    out  pADDR_W  byte count of committed frame
//  Drop         out  1        1-cycle pulse: frame discarded on overflow
//
// BEHAVIOUR
//  Reset: state FILL, pointers 0, Wr_Ready=1, Fifo_Empty=1, Eth_Pkt_Rdy=0,
//    Fifo_Data=0, Frame_Len=0, Drop=0.
//  FSM:
//  - FILL
//    - Wr_Ready=1; each accepted byte stored at wr_ptr, wr_ptr+1.
//    - Accepted byte with Wr_Last: Frame_Len<=wr_ptr+1, rd_ptr<=0, go READY.
//  - FILL overflow
//    - Byte accepted while wr_ptr==pDEPTH: frame discarded, wr_ptr<=0, Drop pulses 1 cycle.
//    - Go DISCARD; if that byte had Wr_Last, return to FILL instead.
//  - DISCARD
//    - Wr_Ready=1; bytes swallowed, not stored.
//    - Accepted Wr_Last: go FILL.
//  - READY
//    - Wr_Ready=0, Eth_Pkt_Rdy=1 (registered, high the cycle after commit).
//    - Tx_En==1: go SEND, Eth_Pkt_Rdy<=0.
//  - SEND
//    - Wr_Ready=0; Fifo_Rd pops mem[rd_ptr] into Fifo_Data (valid the cycle after Fifo_Rd).
//    - rd_ptr+1 on each pop.
//    - Tx_En==0: go FILL, wr_ptr<=0, rd_ptr<=0, Fifo_Empty<=1.
//  Fifo_Empty:
//    - Combinational: 1 in FILL/DISCARD; in READY/SEND, (rd_ptr==Frame_Len).
//    - Deasserts the cycle READY is entered (before TX FSM leaves IDLE).
//    - Asserts the cycle after the last pop.
//  Pop while empty, or in any state but SEND: ignored; rd_ptr and Fifo_Data unchanged.
//  Single byte frame (Valid+Last on first byte): Frame_Len=1, normal READY/SEND path.
//  Wr_Last without Wr_Valid: ignored.
//  Tx_En falling before frame fully drained: remaining bytes discarded, return to FILL.
//  Rst mid-frame or mid-SEND: immediate return to reset values; partial frame lost.
//  Memory: single-port-write/registered-read array, inferable as BRAM.
//  No combinational path from Fifo_Rd to Fifo_Data.
//
// TESTING
//  1. Write 46 bytes 0x00..0x2D, Last on 0x2D
//     -> Eth_Pkt_Rdy=1 next cycle, Frame_Len=46, Fifo_Empty=0, Wr_Ready=0.
//  2. Raise Tx_En, pulse Fifo_Rd every 4 clocks
//     -> Fifo_Data = 0x00,0x01..0x2D, each 1 cycle after pop.
//     -> Fifo_Empty=1 the cycle after 46th pop; Eth_Pkt_Rdy=0 after Tx_En seen.
//  3. Drop Tx_En after frame 1
//     -> Wr_Ready=1 next cycle; second frame 0xA5 x 60 reads back intact.
//  4. Write pDEPTH+1 bytes, then 3 more with Last on final
//     -> Drop pulses once; no Eth_Pkt_Rdy; next 1-byte frame 0x7E commits, Frame_Len=1.
//  5. Fifo_Rd pulsed in FILL and after empty in SEND
//     -> Fifo_Data/rd_ptr unchanged, Fifo_Empty stays 1.
//  6. Assert Rst after 10 pops of a 100-byte frame
//     -> all outputs at reset values next cycle; new frame transfers correctly.

Source files
------------

// File: rtl/eth_tx_pkt_buf.sv
// Single-frame payload buffer between the upstream byte stream and the RMII TX control FSM.
// A frame is filled, committed on Wr_Last, then popped one byte per Fifo_Rd until Tx_En drops.
module eth_tx_pkt_buf #(
  parameter int unsigned pDEPTH  = 1536,
  parameter int unsigned pADDR_W = 11
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [7:0]         Wr_Data,
  input  logic               Wr_Valid,
  input  logic               Wr_Last,
  output logic               Wr_Ready,
  input  logic               Tx_En,
  input  logic               Fifo_Rd,
  output logic [7:0]         Fifo_Data,
  output logic               Fifo_Empty,
  output logic               Eth_Pkt_Rdy,
  output logic [pADDR_W-1:0] Frame_Len,
  output logic               Drop
);

  localparam logic [pADDR_W-1:0] DEPTH_L = pADDR_W'(pDEPTH);

  typedef enum logic [1:0] {
    S_FILL,
    S_DISCARD,
    S_READY,
    S_SEND
  } state_e;

  state_e             state_q;
  logic [pADDR_W-1:0] wr_ptr_q;
  logic [pADDR_W-1:0] rd_ptr_q;
  logic [pADDR_W-1:0] frame_len_q;
  logic [7:0]         fifo_data_q;
  logic               pkt_rdy_q;
  logic               drop_q;

  logic [7:0] mem [pDEPTH];

  logic wr_acc;
  logic fill_full;
  logic mem_we;
  logic empty;
  logic pop;

  assign Wr_Ready  = (state_q == S_FILL) || (state_q == S_DISCARD);
  assign wr_acc    = Wr_Valid && Wr_Ready;
  assign fill_full = (wr_ptr_q == DEPTH_L);
  assign mem_we    = wr_acc && (state_q == S_FILL) && !fill_full;

  // Empty is only meaningful against a committed length; while filling nothing is readable.
  assign empty = ((state_q == S_READY) || (state_q == S_SEND)) ? (rd_ptr_q == frame_len_q) : 1'b1;
  assign pop   = (state_q == S_SEND) && Tx_En && Fifo_Rd && !empty;

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= Wr_Data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_len_q <= '0;
      fifo_data_q <= '0;
      pkt_rdy_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      unique case (state_q)
        S_FILL: begin
          if (wr_acc) begin
            if (fill_full) begin
              // Overflowing byte: throw the frame away and swallow the rest of it.
              wr_ptr_q <= '0;
              drop_q   <= 1'b1;
              state_q  <= Wr_Last ? S_FILL : S_DISCARD;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              if (Wr_Last) begin
                frame_len_q <= wr_ptr_q + 1'b1;
                rd_ptr_q    <= '0;
                pkt_rdy_q   <= 1'b1;
                state_q     <= S_READY;
              end
            end
          end
        end
        S_DISCARD: begin
          if (wr_acc && Wr_Last) begin
            state_q <= S_FILL;
          end
        end
        S_READY: begin
          if (Tx_En) begin
            pkt_rdy_q <= 1'b0;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (!Tx_En) begin
            state_q  <= S_FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
          end else if (pop) begin
            fifo_data_q <= mem[rd_ptr_q];
            rd_ptr_q    <= rd_ptr_q + 1'b1;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign Fifo_Data   = fifo_data_q;
  assign Fifo_Empty  = empty;
  assign Eth_Pkt_Rdy = pkt_rdy_q;
  assign Frame_Len   = frame_len_q;
  assign Drop        = drop_q;

endmodule

// File: tb/tb_eth_tx_pkt_buf.sv
// Directed-plus-random bench for eth_tx_pkt_buf against a queue-based frame model.
module tb_eth_tx_pkt_buf;

  localparam int unsigned DEPTH = 1536;
  localparam int unsigned AW    = 11;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [7:0]    Wr_Data;
  logic          Wr_Valid;
  logic          Wr_Last;
  logic          Wr_Ready;
  logic          Tx_En;
  logic          Fifo_Rd;
  logic [7:0]    Fifo_Data;
  logic          Fifo_Empty;
  logic          Eth_Pkt_Rdy;
  logic [AW-1:0] Frame_Len;
  logic          Drop;

  eth_tx_pkt_buf #(.pDEPTH(DEPTH), .pADDR_W(AW)) dut (
    .Clk(Clk), .Rst(Rst), .Wr_Data(Wr_Data), .Wr_Valid(Wr_Valid), .Wr_Last(Wr_Last),
    .Wr_Ready(Wr_Ready), .Tx_En(Tx_En), .Fifo_Rd(Fifo_Rd), .Fifo_Data(Fifo_Data),
    .Fifo_Empty(Fifo_Empty), .Eth_Pkt_Rdy(Eth_Pkt_Rdy), .Frame_Len(Frame_Len), .Drop(Drop)
  );

  always #5 Clk = ~Clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Model: bytes of the frame being filled, the committed frame, and buffer status.
  byte unsigned fq[$];
  byte unsigned cq[$];
  bit           m_busy = 1'b0;
  bit           m_disc = 1'b0;
  byte unsigned m_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset;
    fq.delete();
    cq.delete();
    m_busy = 1'b0;
    m_disc = 1'b0;
    m_data = 8'h00;
  endtask

  task automatic wr(input byte unsigned d, input bit last);
    bit exp_drop;
    exp_drop = 1'b0;
    chk("wr_ready", {31'd0, Wr_Ready}, {31'd0, !m_busy});
    Wr_Data  = d;
    Wr_Last  = last;
    Wr_Valid = 1'b1;
    if (!m_busy) begin
      if (m_disc) begin
        if (last) m_disc = 1'b0;
      end else if (fq.size() == DEPTH) begin
        exp_drop = 1'b1;
        fq.delete();
        m_disc = !last;
      end else begin
        fq.push_back(d);
        if (last) begin
          cq = fq;
          fq.delete();
          m_busy = 1'b1;
        end
      end
    end
    tick;
    Wr_Valid = 1'b0;
    Wr_Last  = 1'b0;
    chk("drop", {31'd0, Drop}, {31'd0, exp_drop});
  endtask

  task automatic idle_last;
    Wr_Valid = 1'b0;
    Wr_Last  = 1'($urandom_range(0, 1));
    Wr_Data  = 8'($urandom);
    tick;
    Wr_Last = 1'b0;
    chk("drop_idle", {31'd0, Drop}, 32'd0);
  endtask

  task automatic write_frame(input byte unsigned q[$], input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle_last;
      wr(q[i], i == q.size() - 1);
    end
  endtask

  task automatic chk_commit;
    chk("pkt_rdy", {31'd0, Eth_Pkt_Rdy}, 32'd1);
    chk("frame_len", {21'd0, Frame_Len}, cq.size());
    chk("empty_commit", {31'd0, Fifo_Empty}, 32'd0);
    chk("wr_ready_commit", {31'd0, Wr_Ready}, 32'd0);
  endtask

  task automatic drain(input int n);
    Tx_En = 1'b1;
    tick;
    chk("pkt_rdy_send", {31'd0, Eth_Pkt_Rdy}, 32'd0);
    for (int i = 0; i < n; i++) begin
      chk("empty_pre_pop", {31'd0, Fifo_Empty}, 32'd0);
      Fifo_Rd = 1'b1;
      tick;
      Fifo_Rd = 1'b0;
      m_data = cq[i];
      chk("fifo_data", {24'd0, Fifo_Data}, {24'd0, m_data});
      chk("empty_post_pop", {31'd0, Fifo_Empty}, {31'd0, (i == cq.size() - 1)});
      repeat (3) tick;
    end
  endtask

  task automatic end_send(input bit empty_pop);
    if (empty_pop) begin
      Fifo_Rd = 1'b1;
      tick;
      Fifo_Rd = 1'b0;
      chk("data_pop_empty", {24'd0, Fifo_Data}, {24'd0, m_data});
      chk("empty_pop_empty", {31'd0, Fifo_Empty}, 32'd1);
    end
    Tx_En = 1'b0;
    tick;
    m_busy = 1'b0;
    chk("wr_ready_rearm", {31'd0, Wr_Ready}, 32'd1);
    chk("empty_rearm", {31'd0, Fifo_Empty}, 32'd1);
    chk("pkt_rdy_rearm", {31'd0, Eth_Pkt_Rdy}, 32'd0);
  endtask

  task automatic chk_reset_vals;
    chk("rst_wr_ready", {31'd0, Wr_Ready}, 32'd1);
    chk("rst_empty", {31'd0, Fifo_Empty}, 32'd1);
    chk("rst_pkt_rdy", {31'd0, Eth_Pkt_Rdy}, 32'd0);
    chk("rst_data", {24'd0, Fifo_Data}, 32'd0);
    chk("rst_len", {21'd0, Frame_Len}, 32'd0);
    chk("rst_drop", {31'd0, Drop}, 32'd0);
  endtask

  initial begin
    byte unsigned q[$];
    int unsigned  len;
    int unsigned  k;

    Rst = 1'b1; Wr_Data = '0; Wr_Valid = 1'b0; Wr_Last = 1'b0; Tx_En = 1'b0; Fifo_Rd = 1'b0;
    tick;
    tick;
    chk_reset_vals;
    Rst = 1'b0;
    model_reset;
    tick;

    // Pop while filling is ignored
    Fifo_Rd = 1'b1;
    tick;
    Fifo_Rd = 1'b0;
    chk("data_pop_fill", {24'd0, Fifo_Data}, {24'd0, m_data});
    chk("empty_pop_fill", {31'd0, Fifo_Empty}, 32'd1);

    // 46-byte ramp frame
    q.delete();
    for (int i = 0; i < 46; i++) q.push_back(8'(i));
    write_frame(q, 1'b0);
    chk_commit;
    tick;
    tick;
    chk("pkt_rdy_hold", {31'd0, Eth_Pkt_Rdy}, 32'd1);
    chk("wr_ready_hold", {31'd0, Wr_Ready}, 32'd0);
    drain(cq.size());
    end_send(1'b1);

    // 60 x 0xA5
    q.delete();
    for (int i = 0; i < 60; i++) q.push_back(8'hA5);
    write_frame(q, 1'b0);
    chk_commit;
    drain(cq.size());
    end_send(1'b1);

    // Random frames, random gaps, some aborted mid-transmission
    for (int f = 0; f < 5; f++) begin
      len = $urandom_range(1, 120);
      q.delete();
      for (int i = 0; i < int'(len); i++) q.push_back(8'($urandom));
      write_frame(q, 1'b1);
      chk_commit;
      if ($urandom_range(0, 1) == 1 && len > 2) begin
        k = $urandom_range(1, len - 1);
        drain(int'(k));
        end_send(1'b0);
      end else begin
        drain(cq.size());
        end_send(1'b1);
      end
    end

    // Overflow: DEPTH+1 bytes, then 3 more ending with Last
    for (int i = 0; i < int'(DEPTH) + 1; i++) wr(8'($urandom), 1'b0);
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b1);
    chk("pkt_rdy_ovf", {31'd0, Eth_Pkt_Rdy}, 32'd0);
    chk("empty_ovf", {31'd0, Fifo_Empty}, 32'd1);
    chk("wr_ready_ovf", {31'd0, Wr_Ready}, 32'd1);
    wr(8'h7E, 1'b1);
    chk_commit;
    drain(cq.size());
    end_send(1'b1);

    // Reset in the middle of sending a 100-byte frame
    q.delete();
    for (int i = 0; i < 100; i++) q.push_back(8'($urandom));
    write_frame(q, 1'b1);
    chk_commit;
    drain(10);
    Tx_En = 1'b0;
    Rst   = 1'b1;
    tick;
    chk_reset_vals;
    Rst = 1'b0;
    model_reset;
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    write_frame(q, 1'b1);
    chk_commit;
    drain(cq.size());
    end_send(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
